axi_bram_sg_ctrl: RTL and testbench
===================================

// Module: axi_bram_sg_ctrl
// PURPOSE
//  AXI4 full slave over an inferred simple-dual-port BRAM; holds DMA scatter-gather descriptors.
//  Replaces the fixed 32-bit vendor-IP wrapper with a parametrised controller.
//  Adds FIXED/INCR/WRAP bursts, byte strobes, rready back-pressure and post-reset busy.
//  Independent read and write channels; sits between the DMA SG port and the interconnect.
// PARAMETERS
//  DATA_W    32    data width, bits: 32/64/128; BYTES=DATA_W/8, OFF=log2(BYTES)
//  ADDR_W    32    AXI address width
//  ID_W      4     AXI ID width
//  DEPTH     1024  memory words, power of 2; IDX_W=log2(DEPTH)
//  BUSY_CYC  4     cycles rst_busy stays high after reset release
// PORTS
//  s_aclk     in   1         single clock, all logic rising-edge
//  s_areset   in   1         asynchronous, active-high reset
//  rst_busy   out  1         high in reset and BUSY_CYC cycles after
//  s_axi_aw{id,addr,len,size,burst,valid}  in  ID_W,ADDR_W,8,3,2,1   write address
//  s_axi_awready  out  1
//  s_axi_w{data,strb,last,valid}  in  DATA_W,BYTES,1,1   write data
//  s_axi_wready   out  1
//  s_axi_b{id,resp,valid}  out  ID_W,2,1   write response; s_axi_bready in 1
//  s_axi_ar{id,addr,len,size,burst,valid}  in  ID_W,ADDR_W,8,3,2,1   read address
//  s_axi_arready  out  1
//  s_axi_r{id,data,resp,last,valid}  out  ID_W,DATA_W,2,1,1   read data; s_axi_rready in 1
// BEHAVIOUR
//  Reset: all valids/readys 0, resp 0, FSMs idle, rst_busy 1; memory contents NOT cleared.
//  rst_busy: counter from BUSY_CYC to 0 after release; awready/arready forced 0 while 1.
//  Reset mid-burst: burst abandoned; no B/R issued; partial writes stay in memory.
//  Write FSM W_IDLE->W_DATA->W_RESP:
//   W_IDLE: awready=1; on handshake latch id/addr/len/size/burst, beat_cnt=0.
//   W_DATA: wready=1; per beat, byte lane i written iff wstrb[i], index addr[OFF+IDX_W-1:OFF].
//   Burst ends at beat_cnt==len; wlast ignored (beat count governs). Then W_RESP.
//   W_RESP: bvalid=1, bresp=OKAY, bid=latched id; hold until bready, then W_IDLE.
//   Min write latency: last W beat -> bvalid next cycle.
//  Read FSM R_IDLE->R_READ:
//   R_IDLE: arready=1; latch same fields.
//   R_READ: issue a RAM read when 2-entry output FIFO has a free slot incl. in-flight.
//   RAM read latency 1; first rvalid 2 cycles after AR handshake.
//   R_READ -> R_IDLE on last beat issued; rlast=1 on beat len.
//   rvalid/rdata/rlast/rresp/rid stable while rready=0; full throughput with rready=1.
//  Address update per beat (STEP=2^size, size>OFF treated as OFF):
//   FIXED(00): unchanged. INCR(01): addr+STEP, 4 KB boundary not checked.
//   WRAP(10): wraps within aligned (len+1)*STEP window; len not in {1,3,7,15} -> INCR.
//   burst 11: treated as INCR.
//  Same-cycle read and write to one word: read returns OLD data (read-first).
//  Without the macro, indices above DEPTH-1 wrap modulo DEPTH.
// CONFIGURATION
//  AXI_BRAM_ERR_RESP_EN defined: beats with addr >= DEPTH*BYTES are out of range.
//   Out-of-range write: write suppressed; bresp=SLVERR(2'b10) if any beat out of range.
//   Out-of-range read: rdata=0 and rresp=SLVERR for that beat only.
//  AXI_BRAM_ERR_RESP_EN undefined: index wraps modulo DEPTH; bresp/rresp always OKAY.
// STRUCTURE
//  Package axi_bram_pkg: burst codes FIXED/INCR/WRAP, resp codes OKAY/SLVERR,
//   wr_state_t {W_IDLE,W_DATA,W_RESP}, rd_state_t {R_IDLE,R_READ}.
//  Sub-module axi_bram_burst_addr: combinational next-address for addr/len/size/burst.
//   Instantiated once per channel. Memory array and output FIFO inline in top.
// TESTING (DATA_W=32, DEPTH=1024)
//  Reset, BUSY_CYC=4 -> rst_busy high 4 cycles after release; awready/arready 0 until low.
//  INCR AW addr 0x10 len 3, data 1..4, strb F -> bresp OKAY, bid echoed.
//   INCR AR of same burst -> 1,2,3,4, rlast on 4th, first rvalid 2 cycles after AR.
//  WRAP AW addr 0x38 len 3 -> beats land at 0x38,0x3C,0x30,0x34; readback confirms order.
//  rready toggled 1-0-0-1 on 8-beat INCR read -> no data lost or duplicated, rdata stable.
//  strb 4'b0101 over 0xFFFFFFFF, data 0x11223344 -> readback 0xFF22FF44.
//   FIXED len 2 at 0x0 -> only last beat's data remains.
//  ERR_EN: AW addr 0xFFC len 1 -> word 0x3FF written, bresp SLVERR.
//   AR 0x1000 -> rdata 0, rresp SLVERR; no macro: 0x1000 aliases word 0.

Source files
------------

// File: rtl/axi_bram_pkg.sv
// Shared definitions for the AXI4 BRAM scatter-gather descriptor controller:
// burst and response encodings and the write/read channel state types.
package axi_bram_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;
  typedef enum logic       {R_IDLE, R_READ}         rd_state_t;

endpackage

// File: rtl/axi_bram_burst_addr.sv
// Next-beat address for an AXI4 burst (FIXED / INCR / WRAP).
// Ports:
//   addr      in  current beat address
//   len       in  AXI burst length (beats - 1)
//   size      in  AXI beat size; sizes wider than the bus are clamped to OFF
//   burst     in  AXI burst type; reserved code 11 behaves as INCR
//   next_addr out address of the following beat (combinational)
module axi_bram_burst_addr #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned OFF    = 2
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        len,
  input  logic [2:0]        size,
  input  logic [1:0]        burst,
  output logic [ADDR_W-1:0] next_addr
);
  import axi_bram_pkg::*;

  logic [2:0]        eff_size;
  logic [ADDR_W-1:0] step;
  logic [ADDR_W-1:0] incr;
  logic [ADDR_W-1:0] mask;
  logic              wrap_ok;

  always_comb begin
    eff_size = (size > 3'(OFF)) ? 3'(OFF) : size;
    step     = ADDR_W'(1) << eff_size;
    incr     = addr + step;
    // Wrap window is (len+1)*STEP bytes, aligned to its own size.
    mask     = ((ADDR_W'(len) + ADDR_W'(1)) << eff_size) - ADDR_W'(1);
    wrap_ok  = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_INCR:  next_addr = incr;
      BURST_WRAP:  next_addr = wrap_ok ? ((addr & ~mask) | (incr & mask)) : incr;
      default:     next_addr = incr;
    endcase
  end

endmodule

// File: rtl/axi_bram_sg_ctrl.sv
// AXI4 full slave over an inferred simple-dual-port BRAM holding DMA
// scatter-gather descriptors. Independent write and read channels.
// Ports:
//   s_aclk, s_areset        clock, asynchronous active-high reset
//   rst_busy                high in reset and BUSY_CYC cycles after release
//   s_axi_aw*/w*/b*         AXI4 write address, data and response channels
//   s_axi_ar*/r*            AXI4 read address and data channels
// Optional build macro AXI_BRAM_ERR_RESP_EN: beats at or beyond DEPTH*BYTES
// are suppressed (writes) or return zero data (reads) with SLVERR. Without
// it the word index wraps modulo DEPTH and responses are always OKAY.
module axi_bram_sg_ctrl #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned ID_W     = 4,
  parameter int unsigned DEPTH    = 1024,
  parameter int unsigned BUSY_CYC = 4
) (
  input  logic                s_aclk,
  input  logic                s_areset,
  output logic                rst_busy,
  input  logic [ID_W-1:0]     s_axi_awid,
  input  logic [ADDR_W-1:0]   s_axi_awaddr,
  input  logic [7:0]          s_axi_awlen,
  input  logic [2:0]          s_axi_awsize,
  input  logic [1:0]          s_axi_awburst,
  input  logic                s_axi_awvalid,
  output logic                s_axi_awready,
  input  logic [DATA_W-1:0]   s_axi_wdata,
  input  logic [DATA_W/8-1:0] s_axi_wstrb,
  input  logic                s_axi_wlast,
  input  logic                s_axi_wvalid,
  output logic                s_axi_wready,
  output logic [ID_W-1:0]     s_axi_bid,
  output logic [1:0]          s_axi_bresp,
  output logic                s_axi_bvalid,
  input  logic                s_axi_bready,
  input  logic [ID_W-1:0]     s_axi_arid,
  input  logic [ADDR_W-1:0]   s_axi_araddr,
  input  logic [7:0]          s_axi_arlen,
  input  logic [2:0]          s_axi_arsize,
  input  logic [1:0]          s_axi_arburst,
  input  logic                s_axi_arvalid,
  output logic                s_axi_arready,
  output logic [ID_W-1:0]     s_axi_rid,
  output logic [DATA_W-1:0]   s_axi_rdata,
  output logic [1:0]          s_axi_rresp,
  output logic                s_axi_rlast,
  output logic                s_axi_rvalid,
  input  logic                s_axi_rready
);
  import axi_bram_pkg::*;

  localparam int unsigned BYTES  = DATA_W / 8;
  localparam int unsigned OFF    = $clog2(BYTES);
  localparam int unsigned IDX_W  = $clog2(DEPTH);
  localparam int unsigned BUSY_W = (BUSY_CYC < 1) ? 1 : $clog2(BUSY_CYC + 1);

  // Burst length is counted by beats; wlast carries no extra information.
  logic unused_wlast;
  assign unused_wlast = s_axi_wlast;

  // Post-reset busy window; busy_nx is the value rst_busy takes next edge.
  logic [BUSY_W-1:0] busy_cnt;
  logic              busy_nx;
  assign busy_nx = busy_cnt > BUSY_W'(1);

  always_ff @(posedge s_aclk or posedge s_areset) begin
    if (s_areset) begin
      busy_cnt <= BUSY_W'(BUSY_CYC);
      rst_busy <= 1'b1;
    end else begin
      if (busy_cnt != '0) busy_cnt <= busy_cnt - BUSY_W'(1);
      rst_busy <= busy_nx;
    end
  end

  // ---------------- write channel ----------------
  wr_state_t         w_state;
  logic [ID_W-1:0]   w_id;
  logic [ADDR_W-1:0] w_addr, w_next;
  logic [7:0]        w_len, w_cnt;
  logic [2:0]        w_size;
  logic [1:0]        w_burst;
  logic              w_err;
  logic              w_oor_c, w_fire_c, mem_we_c;
  logic [IDX_W-1:0]  w_idx;

  axi_bram_burst_addr #(.ADDR_W(ADDR_W), .OFF(OFF)) u_waddr (
    .addr(w_addr), .len(w_len), .size(w_size), .burst(w_burst), .next_addr(w_next)
  );

`ifdef AXI_BRAM_ERR_RESP_EN
  assign w_oor_c = w_addr >= ADDR_W'(DEPTH * BYTES);
`else
  assign w_oor_c = 1'b0;
`endif
  assign w_idx    = w_addr[OFF+IDX_W-1:OFF];
  assign w_fire_c = (w_state == W_DATA) && s_axi_wready && s_axi_wvalid;
  assign mem_we_c = w_fire_c && !w_oor_c;

  always_ff @(posedge s_aclk or posedge s_areset) begin
    if (s_areset) begin
      w_state       <= W_IDLE;
      w_id          <= '0;
      w_addr        <= '0;
      w_len         <= '0;
      w_size        <= '0;
      w_burst       <= '0;
      w_cnt         <= '0;
      w_err         <= 1'b0;
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bresp   <= RESP_OKAY;
      s_axi_bid     <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (s_axi_awready && s_axi_awvalid) begin
            w_id          <= s_axi_awid;
            w_addr        <= s_axi_awaddr;
            w_len         <= s_axi_awlen;
            w_size        <= s_axi_awsize;
            w_burst       <= s_axi_awburst;
            w_cnt         <= '0;
            w_err         <= 1'b0;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b1;
            w_state       <= W_DATA;
          end else begin
            s_axi_awready <= !busy_nx;
          end
        end
        W_DATA: begin
          if (w_fire_c) begin
            if (w_cnt == w_len) begin
              s_axi_wready <= 1'b0;
              s_axi_bvalid <= 1'b1;
              s_axi_bresp  <= (w_err || w_oor_c) ? RESP_SLVERR : RESP_OKAY;
              s_axi_bid    <= w_id;
              w_state      <= W_RESP;
            end else begin
              w_addr <= w_next;
              w_cnt  <= w_cnt + 8'd1;
              w_err  <= w_err || w_oor_c;
            end
          end
        end
        W_RESP: begin
          if (s_axi_bready) begin
            s_axi_bvalid  <= 1'b0;
            s_axi_awready <= !busy_nx;
            w_state       <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // ---------------- read channel ----------------
  rd_state_t         r_state;
  logic [ID_W-1:0]   r_id;
  logic [ADDR_W-1:0] r_addr, r_next;
  logic [7:0]        r_len, r_cnt;
  logic [2:0]        r_size;
  logic [1:0]        r_burst;
  logic              r_oor_c, issue_c, pop_c;
  logic [IDX_W-1:0]  r_idx;
  logic [1:0]        occ_c;

  // RAM read in flight (data lands in mem_q one cycle after issue).
  logic              pend_v, pend_last, pend_err;
  logic [ID_W-1:0]   pend_id;
  logic [DATA_W-1:0] mem_q, push_data_c;
  logic [1:0]        push_resp_c;

  // Second FIFO slot; the first slot is the R channel output register set.
  logic              s1_v, s1_last;
  logic [ID_W-1:0]   s1_id;
  logic [DATA_W-1:0] s1_data;
  logic [1:0]        s1_resp;

  axi_bram_burst_addr #(.ADDR_W(ADDR_W), .OFF(OFF)) u_raddr (
    .addr(r_addr), .len(r_len), .size(r_size), .burst(r_burst), .next_addr(r_next)
  );

`ifdef AXI_BRAM_ERR_RESP_EN
  assign r_oor_c = r_addr >= ADDR_W'(DEPTH * BYTES);
`else
  assign r_oor_c = 1'b0;
`endif
  assign r_idx       = r_addr[OFF+IDX_W-1:OFF];
  assign pop_c       = s_axi_rvalid && s_axi_rready;
  assign occ_c       = 2'(s_axi_rvalid) + 2'(s1_v) + 2'(pend_v);
  // Issue only if the read still has a FIFO slot after this cycle's pop.
  assign issue_c     = (r_state == R_READ) && ((occ_c - 2'(pop_c)) < 2'd2);
  assign push_data_c = pend_err ? '0 : mem_q;
  assign push_resp_c = pend_err ? RESP_SLVERR : RESP_OKAY;

  // Memory array: no reset, read-first on a same-word collision.
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge s_aclk) begin
    if (issue_c) mem_q <= mem[r_idx];
    for (int unsigned i = 0; i < BYTES; i++) begin
      if (mem_we_c && s_axi_wstrb[i]) mem[w_idx][8*i +: 8] <= s_axi_wdata[8*i +: 8];
    end
  end

  always_ff @(posedge s_aclk or posedge s_areset) begin
    if (s_areset) begin
      r_state       <= R_IDLE;
      r_id          <= '0;
      r_addr        <= '0;
      r_len         <= '0;
      r_size        <= '0;
      r_burst       <= '0;
      r_cnt         <= '0;
      s_axi_arready <= 1'b0;
      pend_v        <= 1'b0;
      pend_last     <= 1'b0;
      pend_err      <= 1'b0;
      pend_id       <= '0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rdata   <= '0;
      s_axi_rresp   <= RESP_OKAY;
      s_axi_rlast   <= 1'b0;
      s_axi_rid     <= '0;
      s1_v          <= 1'b0;
      s1_last       <= 1'b0;
      s1_id         <= '0;
      s1_data       <= '0;
      s1_resp       <= RESP_OKAY;
    end else begin
      pend_v <= issue_c;
      if (issue_c) begin
        pend_last <= (r_cnt == r_len);
        pend_err  <= r_oor_c;
        pend_id   <= r_id;
      end

      case (r_state)
        R_IDLE: begin
          if (s_axi_arready && s_axi_arvalid) begin
            r_id          <= s_axi_arid;
            r_addr        <= s_axi_araddr;
            r_len         <= s_axi_arlen;
            r_size        <= s_axi_arsize;
            r_burst       <= s_axi_arburst;
            r_cnt         <= '0;
            s_axi_arready <= 1'b0;
            r_state       <= R_READ;
          end else begin
            s_axi_arready <= !busy_nx;
          end
        end
        R_READ: begin
          if (issue_c) begin
            if (r_cnt == r_len) begin
              s_axi_arready <= !busy_nx;
              r_state       <= R_IDLE;
            end else begin
              r_addr <= r_next;
              r_cnt  <= r_cnt + 8'd1;
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase

      // Output FIFO: head only moves on pop, so R payload holds under stall.
      if (pop_c) begin
        if (s1_v) begin
          s_axi_rdata <= s1_data;
          s_axi_rresp <= s1_resp;
          s_axi_rlast <= s1_last;
          s_axi_rid   <= s1_id;
          s1_v        <= pend_v;
          if (pend_v) begin
            s1_data <= push_data_c;
            s1_resp <= push_resp_c;
            s1_last <= pend_last;
            s1_id   <= pend_id;
          end
        end else if (pend_v) begin
          s_axi_rdata <= push_data_c;
          s_axi_rresp <= push_resp_c;
          s_axi_rlast <= pend_last;
          s_axi_rid   <= pend_id;
        end else begin
          s_axi_rvalid <= 1'b0;
        end
      end else if (pend_v) begin
        if (!s_axi_rvalid) begin
          s_axi_rvalid <= 1'b1;
          s_axi_rdata  <= push_data_c;
          s_axi_rresp  <= push_resp_c;
          s_axi_rlast  <= pend_last;
          s_axi_rid    <= pend_id;
        end else begin
          s1_v    <= 1'b1;
          s1_data <= push_data_c;
          s1_resp <= push_resp_c;
          s1_last <= pend_last;
          s1_id   <= pend_id;
        end
      end
    end
  end

endmodule

// File: tb/tb_axi_bram_sg_ctrl.sv
// Directed bench for axi_bram_sg_ctrl (DATA_W=32, DEPTH=1024, BUSY_CYC=4).
// Expectations follow AXI_BRAM_ERR_RESP_EN when the bench is built with it.
module tb_axi_bram_sg_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        rst_busy;
  logic [3:0]  awid;   logic [31:0] awaddr; logic [7:0] awlen; logic [2:0] awsize;
  logic [1:0]  awburst; logic awvalid; logic awready;
  logic [31:0] wdata;  logic [3:0]  wstrb;  logic wlast; logic wvalid; logic wready;
  logic [3:0]  bid;    logic [1:0]  bresp;  logic bvalid; logic bready;
  logic [3:0]  arid;   logic [31:0] araddr; logic [7:0] arlen; logic [2:0] arsize;
  logic [1:0]  arburst; logic arvalid; logic arready;
  logic [3:0]  rid;    logic [31:0] rdata;  logic [1:0] rresp; logic rlast; logic rvalid;
  logic        rready;

  int vecs = 0;
  int errs = 0;

  logic [31:0] wd [16];
  logic [31:0] ed [16];
  logic [1:0]  er [16];

  localparam logic [1:0] FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10;
`ifdef AXI_BRAM_ERR_RESP_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  axi_bram_sg_ctrl dut (
    .s_aclk(clk), .s_areset(rst), .rst_busy(rst_busy),
    .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(awsize),
    .s_axi_awburst(awburst), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast), .s_axi_wvalid(wvalid),
    .s_axi_wready(wready),
    .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arsize(arsize),
    .s_axi_arburst(arburst), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready)
  );

  task automatic wr_burst(input string nm, input logic [3:0] id, input logic [31:0] addr,
                          input int len, input logic [1:0] burst, input logic [3:0] strb,
                          input logic [1:0] exp_resp);
    int n;
    awid = id; awaddr = addr; awlen = 8'(len); awsize = 3'd2; awburst = burst; awvalid = 1'b1;
    n = 0;
    while (!awready && n < 100) begin @(posedge clk); #1; n++; end
    if (!awready) begin
      vecs++; errs++; $display("FAIL %s aw_timeout awready=%b want 1", nm, awready);
      awvalid = 1'b0; return;
    end
    @(posedge clk); #1; awvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      wdata = wd[i]; wstrb = strb; wlast = (i == len); wvalid = 1'b1;
      n = 0;
      while (!wready && n < 100) begin @(posedge clk); #1; n++; end
      if (!wready) begin
        vecs++; errs++; $display("FAIL %s w_timeout beat=%0d wready=%b want 1", nm, i, wready);
        wvalid = 1'b0; return;
      end
      @(posedge clk); #1;
    end
    wvalid = 1'b0; wlast = 1'b0;
    vecs++;
    if (bvalid !== 1'b1) begin errs++; $display("FAIL %s bvalid_latency got=%b want 1", nm, bvalid); end
    bready = 1'b1;
    n = 0;
    while (!bvalid && n < 100) begin @(posedge clk); #1; n++; end
    vecs++;
    if (bresp !== exp_resp) begin errs++; $display("FAIL %s bresp got=%b want %b", nm, bresp, exp_resp); end
    vecs++;
    if (bid !== id) begin errs++; $display("FAIL %s bid got=%h want %h", nm, bid, id); end
    @(posedge clk); #1; bready = 1'b0;
    vecs++;
    if (bvalid !== 1'b0) begin errs++; $display("FAIL %s bvalid_drop got=%b want 0", nm, bvalid); end
  endtask

  task automatic rd_burst(input string nm, input logic [3:0] id, input logic [31:0] addr,
                          input int len, input logic [1:0] burst, input logic [3:0] pat,
                          input bit chk_lat);
    int n, got, cyc, first;
    logic held, hl;
    logic [31:0] hd;
    arid = id; araddr = addr; arlen = 8'(len); arsize = 3'd2; arburst = burst; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 100) begin @(posedge clk); #1; n++; end
    if (!arready) begin
      vecs++; errs++; $display("FAIL %s ar_timeout arready=%b want 1", nm, arready);
      arvalid = 1'b0; return;
    end
    @(posedge clk); #1; arvalid = 1'b0;
    got = 0; cyc = 0; first = -1; held = 1'b0; hd = '0; hl = 1'b0;
    while (got <= len && cyc < 300) begin
      rready = pat[cyc % 4];
      if (rvalid) begin
        if (first < 0) first = cyc;
        if (held) begin
          vecs++;
          if (rdata !== hd || rlast !== hl) begin
            errs++; $display("FAIL %s stall_hold got=%h/%b want %h/%b", nm, rdata, rlast, hd, hl);
          end
        end
        if (rready) begin
          vecs++;
          if (rdata !== ed[got]) begin errs++; $display("FAIL %s rdata[%0d] got=%h want %h", nm, got, rdata, ed[got]); end
          vecs++;
          if (rlast !== (got == len)) begin errs++; $display("FAIL %s rlast[%0d] got=%b want %b", nm, got, rlast, (got == len)); end
          vecs++;
          if (rresp !== er[got]) begin errs++; $display("FAIL %s rresp[%0d] got=%b want %b", nm, got, rresp, er[got]); end
          vecs++;
          if (rid !== id) begin errs++; $display("FAIL %s rid[%0d] got=%h want %h", nm, got, rid, id); end
          got++; held = 1'b0;
        end else begin
          held = 1'b1; hd = rdata; hl = rlast;
        end
      end
      @(posedge clk); #1; cyc++;
    end
    rready = 1'b0;
    if (got <= len) begin
      vecs++; errs++; $display("FAIL %s r_timeout beats=%0d want %0d", nm, got, len + 1);
    end
    if (chk_lat) begin
      vecs++;
      if (first !== 2) begin errs++; $display("FAIL %s first_rvalid_cycle got=%0d want 2", nm, first); end
    end
    vecs++;
    if (rvalid !== 1'b0) begin errs++; $display("FAIL %s extra_beat rvalid=%b want 0", nm, rvalid); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vecs++;
    if ({rst_busy, awready, arready, wready, bvalid, rvalid} !== 6'b100000) begin
      errs++; $display("FAIL reset_outputs got=%b want 100000", {rst_busy, awready, arready, wready, bvalid, rvalid});
    end
    vecs++;
    if ({bresp, rresp} !== 4'b0000) begin errs++; $display("FAIL reset_resp got=%b want 0000", {bresp, rresp}); end
    rst = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      vecs++;
      if (rst_busy !== (k < 4)) begin errs++; $display("FAIL busy_cycle%0d got=%b want %b", k, rst_busy, (k < 4)); end
      vecs++;
      if (awready !== (k >= 4) || arready !== (k >= 4)) begin
        errs++; $display("FAIL ready_cycle%0d got=%b%b want %b%b", k, awready, arready, (k >= 4), (k >= 4));
      end
    end
  endtask

  task automatic test_incr();
    for (int i = 0; i < 4; i++) begin wd[i] = 32'(i + 1); ed[i] = 32'(i + 1); er[i] = 2'b00; end
    wr_burst("incr_wr", 4'h5, 32'h10, 3, INCR, 4'hF, 2'b00);
    rd_burst("incr_rd", 4'h9, 32'h10, 3, INCR, 4'b1111, 1'b1);
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 4; i++) wd[i] = 32'hA0A0_0000 + 32'(i);
    wr_burst("wrap_wr", 4'h3, 32'h38, 3, WRAP, 4'hF, 2'b00);
    ed[0] = 32'hA0A0_0002; ed[1] = 32'hA0A0_0003; ed[2] = 32'hA0A0_0000; ed[3] = 32'hA0A0_0001;
    for (int i = 0; i < 4; i++) er[i] = 2'b00;
    rd_burst("wrap_rd_incr", 4'h4, 32'h30, 3, INCR, 4'b1111, 1'b0);
    for (int i = 0; i < 4; i++) ed[i] = 32'hA0A0_0000 + 32'(i);
    rd_burst("wrap_rd_wrap", 4'h6, 32'h38, 3, WRAP, 4'b1111, 1'b0);
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 8; i++) begin wd[i] = 32'h1000 + 32'(i); ed[i] = wd[i]; er[i] = 2'b00; end
    wr_burst("bp_wr", 4'hA, 32'h100, 7, INCR, 4'hF, 2'b00);
    rd_burst("bp_rd", 4'hB, 32'h100, 7, INCR, 4'b1001, 1'b1);
  endtask

  task automatic test_strobe();
    wd[0] = 32'hFFFF_FFFF;
    wr_burst("strb_fill", 4'h1, 32'h200, 0, INCR, 4'hF, 2'b00);
    wd[0] = 32'h1122_3344;
    wr_burst("strb_part", 4'h2, 32'h200, 0, INCR, 4'b0101, 2'b00);
    ed[0] = 32'hFF22_FF44; er[0] = 2'b00;
    rd_burst("strb_rd", 4'h2, 32'h200, 0, INCR, 4'b1111, 1'b0);
  endtask

  task automatic test_fixed();
    wd[0] = 32'h0F0F_0001; wd[1] = 32'h0F0F_0002; wd[2] = 32'h0F0F_0003;
    wr_burst("fixed_wr", 4'h7, 32'h0, 2, FIXED, 4'hF, 2'b00);
    for (int i = 0; i < 3; i++) begin ed[i] = 32'h0F0F_0003; er[i] = 2'b00; end
    rd_burst("fixed_rd", 4'h8, 32'h0, 2, FIXED, 4'b1111, 1'b0);
  endtask

  task automatic test_err();
    wd[0] = 32'hCAFE_F00D; wd[1] = 32'hDEAD_BEEF;
    wr_burst("edge_wr", 4'hC, 32'hFFC, 1, INCR, 4'hF, ERR_EN ? 2'b10 : 2'b00);
    ed[0] = 32'hCAFE_F00D; er[0] = 2'b00;
    ed[1] = ERR_EN ? 32'h0 : 32'hDEAD_BEEF; er[1] = ERR_EN ? 2'b10 : 2'b00;
    rd_burst("edge_rd", 4'hD, 32'hFFC, 1, INCR, 4'b1111, 1'b0);
    ed[0] = ERR_EN ? 32'h0 : 32'hDEAD_BEEF; er[0] = ERR_EN ? 2'b10 : 2'b00;
    rd_burst("oor_rd", 4'hE, 32'h1000, 0, INCR, 4'b1111, 1'b0);
  endtask

  task automatic test_reset_mid_burst();
    int n;
    awid = 4'h2; awaddr = 32'h300; awlen = 8'd3; awsize = 3'd2; awburst = INCR; awvalid = 1'b1;
    n = 0;
    while (!awready && n < 100) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1; awvalid = 1'b0;
    wd[0] = 32'h77; wd[1] = 32'h88;
    for (int i = 0; i < 2; i++) begin
      wdata = wd[i]; wstrb = 4'hF; wvalid = 1'b1;
      n = 0;
      while (!wready && n < 100) begin @(posedge clk); #1; n++; end
      @(posedge clk); #1;
    end
    wvalid = 1'b0;
    rst = 1'b1; #2;
    vecs++;
    if ({rst_busy, wready, bvalid, awready} !== 4'b1000) begin
      errs++; $display("FAIL midrst_async got=%b want 1000", {rst_busy, wready, bvalid, awready});
    end
    @(posedge clk); #1; rst = 1'b0;
    n = 0;
    while (rst_busy && n < 50) begin @(posedge clk); #1; n++; end
    vecs++;
    if (rst_busy !== 1'b0 || bvalid !== 1'b0) begin
      errs++; $display("FAIL midrst_recover busy=%b bvalid=%b want 0 0", rst_busy, bvalid);
    end
    ed[0] = 32'h77; ed[1] = 32'h88; er[0] = 2'b00; er[1] = 2'b00;
    rd_burst("midrst_rd", 4'h1, 32'h300, 1, INCR, 4'b1111, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
    rready = 1'b0;
    #1;
    test_reset();
    test_incr();
    test_wrap();
    test_backpressure();
    test_strobe();
    test_fixed();
    test_err();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
